// File: rtl/retire_trace.sv
// Retired-instruction trace: buffers retire records in a small FIFO and
// streams each one out as a byte frame. Optional dmem fields: RETIRE_TRACE_DMEM_EN.
module retire_trace #(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_vld,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_res,
  input  logic [4:0]  i_rd_waddr,
  input  logic        i_rd_wen,
  input  logic        i_break,
  input  logic [31:0] i_dmem_addr,
  input  logic [3:0]  i_dmem_mask,
  input  logic        i_dmem_ren,
  input  logic        i_dmem_wen,
  output logic        o_tvalid,
  output logic [7:0]  o_tdata,
  output logic        o_tlast,
  input  logic        i_tready,
  output logic        o_overflow,
  output logic [7:0]  o_drop_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef RETIRE_TRACE_DMEM_EN
  localparam int NB = 18;
`else
  localparam int NB = 13;
`endif
  localparam int RW = NB * 8;
  localparam logic [4:0] LAST_IDX = 5'(NB - 1);

  typedef enum logic {IDLE, SEND} state_e;

  // Record is packed in wire order: byte 0 (header) sits in the low bits.
  logic [RW-1:0] rec_in;
  logic [7:0]    hdr;

  assign hdr = {i_break, i_rd_wen, 1'b0, i_rd_waddr};

`ifdef RETIRE_TRACE_DMEM_EN
  assign rec_in = {2'b00, i_dmem_ren, i_dmem_wen, i_dmem_mask,
                   i_dmem_addr, i_res, i_inst, i_pc, hdr};
`else
  logic unused_dmem;
  assign unused_dmem = ^{i_dmem_addr, i_dmem_mask, i_dmem_ren, i_dmem_wen};
  assign rec_in = {i_res, i_inst, i_pc, hdr};
`endif

  logic [RW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q, wr_d;
  logic [AW:0]   rd_q, rd_d;
  state_e        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [RW-1:0] sh_q, sh_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    cnt_q, cnt_d;

  logic full, empty, xfer, last, pop, push, drop;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign xfer  = (state_q == SEND) && i_tready;
  assign last  = (idx_q == LAST_IDX);
  assign pop   = !empty && ((state_q == IDLE) || (xfer && last));
  assign push  = i_vld && (!full || pop) && !i_rst;
  assign drop  = i_vld && full && !pop;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
    if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
    // A pop always loads the shift register, in IDLE or at frame end.
    if (pop) begin
      sh_d    = mem_q[rd_q[AW-1:0]];
      idx_d   = '0;
      state_d = SEND;
    end else if (xfer) begin
      if (last) begin
        idx_d   = '0;
        state_d = IDLE;
      end else begin
        sh_d  = sh_q >> 8;
        idx_d = idx_q + 5'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= rec_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_tvalid   = (state_q == SEND);
  assign o_tdata    = (state_q == SEND) ? sh_q[7:0] : 8'h00;
  assign o_tlast    = (state_q == SEND) && last;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = cnt_q;

endmodule

// File: tb/tb_retire_trace.sv
// Scoreboard bench for retire_trace: stimulus queues expected bytes,
// a negedge monitor pops and compares each transferred byte.
module tb_retire_trace;

`ifdef RETIRE_TRACE_DMEM_EN
  localparam int NB = 18;
`else
  localparam int NB = 13;
`endif

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_vld = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_inst = '0;
  logic [31:0] i_res = '0;
  logic [4:0]  i_rd_waddr = '0;
  logic        i_rd_wen = 1'b0;
  logic        i_break = 1'b0;
  logic [31:0] i_dmem_addr = '0;
  logic [3:0]  i_dmem_mask = '0;
  logic        i_dmem_ren = 1'b0;
  logic        i_dmem_wen = 1'b0;
  logic        i_tready = 1'b1;
  logic        o_tvalid;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  logic [8:0] sb [$];

  always #5 clk = ~clk;

  retire_trace #(.DEPTH(4)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_vld(i_vld),
    .i_pc(i_pc), .i_inst(i_inst), .i_res(i_res),
    .i_rd_waddr(i_rd_waddr), .i_rd_wen(i_rd_wen), .i_break(i_break),
    .i_dmem_addr(i_dmem_addr), .i_dmem_mask(i_dmem_mask),
    .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen),
    .o_tvalid(o_tvalid), .o_tdata(o_tdata), .o_tlast(o_tlast),
    .i_tready(i_tready), .o_overflow(o_overflow),
    .o_drop_cnt(o_drop_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected frame from record fields.
  task automatic model(input logic [31:0] pc, inst, res,
                       input logic [4:0] rd, input logic wen, brk,
                       input logic [31:0] da, input logic [3:0] dm,
                       input logic dr, dw);
    logic [7:0] b [$];
    b.push_back({brk, wen, 1'b0, rd});
    for (int i = 0; i < 4; i++) b.push_back(pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) b.push_back(inst[8*i +: 8]);
    for (int i = 0; i < 4; i++) b.push_back(res[8*i +: 8]);
`ifdef RETIRE_TRACE_DMEM_EN
    for (int i = 0; i < 4; i++) b.push_back(da[8*i +: 8]);
    b.push_back({2'b00, dr, dw, dm});
`endif
    for (int i = 0; i < b.size(); i++)
      sb.push_back({i == b.size() - 1, b[i]});
  endtask

  // Called at posedge+1; leaves i_vld low at the following posedge+1.
  task automatic send(input logic [31:0] pc, inst, res,
                      input logic [4:0] rd, input logic wen, brk,
                      input logic [31:0] da, input logic [3:0] dm,
                      input logic dr, dw, input bit exp);
    i_vld = 1'b1; i_pc = pc; i_inst = inst; i_res = res;
    i_rd_waddr = rd; i_rd_wen = wen; i_break = brk;
    i_dmem_addr = da; i_dmem_mask = dm;
    i_dmem_ren = dr; i_dmem_wen = dw;
    if (exp) model(pc, inst, res, rd, wen, brk, da, dm, dr, dw);
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      @(posedge clk); n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic wait_xfers(input int target);
    int n = 0;
    while (xfers < target && n < 100) begin
      @(posedge clk); n++;
    end
    chk("xfer_wait_timeout", (xfers >= target), 1);
    #1;
  endtask

  // Monitor: byte compare plus hold-while-stalled check.
  logic       stall = 1'b0;
  logic [7:0] hd;
  logic       hl;
  initial forever begin
    logic [8:0] e;
    @(negedge clk);
    if (i_rst) stall = 1'b0;
    else begin
      if (stall) begin
        checks++;
        if (!o_tvalid || o_tdata !== hd || o_tlast !== hl) begin
          errors++;
          $display("FAIL hold: v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   o_tvalid, o_tdata, o_tlast, hd, hl);
        end
      end
      if (o_tvalid && i_tready) begin
        checks++;
        xfers++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %h/%b expected none",
                   o_tdata, o_tlast);
        end else begin
          e = sb.pop_front();
          if ({o_tlast, o_tdata} !== e) begin
            errors++;
            $display("FAIL byte: got last=%b data=%h expected last=%b data=%h",
                     o_tlast, o_tdata, e[8], e[7:0]);
          end
        end
      end
      stall = o_tvalid && !i_tready;
      hd = o_tdata;
      hl = o_tlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b028 [13];
    int n;
    b028 = '{8'h41, 8'h00, 8'h01, 8'h00, 8'h00, 8'h93, 8'h00,
             8'hA0, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_tdata", o_tdata, 0);
    chk("rst_tlast", o_tlast, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_cnt", o_drop_cnt, 0);
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(posedge clk); #1;

    // Hand-computed single frame and first-byte latency
    for (int i = 0; i < 13; i++)
      sb.push_back({(i == NB - 1), b028[i]});
`ifdef RETIRE_TRACE_DMEM_EN
    for (int i = 0; i < 5; i++) sb.push_back({(i == 4), 8'h00});
`endif
    send(32'h100, 32'h00A00093, 32'hA, 5'd1, 1'b1, 1'b0,
         '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_cycle1_tvalid", o_tvalid, 0);
    @(negedge clk);
    chk("lat_cycle2_tvalid", o_tvalid, 1);
    drain(40);

    // Stall for five cycles mid-frame
    @(posedge clk); #1;
    n = xfers;
    send(32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd31, 1'b1, 1'b1,
         32'h0000_1000, 4'b0011, 1'b1, 1'b0, 1'b1);
    wait_xfers(n + 4);
    i_tready = 1'b0;
    repeat (5) @(posedge clk);
    chk("stall_tvalid", o_tvalid, 1);
    #1 i_tready = 1'b1;
    drain(40);

    // Back-to-back frames, no bubble
    @(posedge clk); #1;
    send(32'h0000_0200, 32'h0010_0113, 32'h2, 5'd2, 1'b1, 1'b0,
         '0, '0, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0204, 32'h0020_0193, 32'h3, 5'd3, 1'b0, 1'b0,
         '0, '0, 1'b0, 1'b0, 1'b1);
    n = 0;
    for (int k = 0; k < 10 && !o_tvalid; k++) @(negedge clk);
    for (int i = 0; i < 2 * NB; i++) begin
      if (o_tvalid) n++;
      @(negedge clk);
    end
    chk("b2b_valid_cycles", n, 2 * NB);
    drain(40);

    // Overflow: 7 records with sink stalled, DEPTH=4
    @(posedge clk); #1;
    i_tready = 1'b0;
    for (int r = 0; r < 7; r++)
      send(32'h1000 + 32'(4 * r), 32'h13 + 32'(r), 32'(r), 5'(r), 1'b1,
           1'b0, '0, '0, 1'b0, 1'b0, (r < 5));
    @(negedge clk);
    chk("ovf_set", o_overflow, 1);
    chk("drop_cnt", o_drop_cnt, 2);
    @(posedge clk); #1;
    i_tready = 1'b1;
    drain(200);
    chk("ovf_sticky", o_overflow, 1);

    // Reset in the middle of a frame
    @(posedge clk); #1;
    n = xfers;
    send(32'h0000_0300, 32'h0000_0073, 32'h0, 5'd0, 1'b0, 1'b1,
         '0, '0, 1'b0, 1'b0, 1'b1);
    wait_xfers(n + 6);
    i_rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    i_rst = 1'b0;
    @(negedge clk);
    chk("midrst_tvalid", o_tvalid, 0);
    chk("midrst_tlast", o_tlast, 0);
    chk("midrst_ovf", o_overflow, 0);
    chk("midrst_cnt", o_drop_cnt, 0);
    @(posedge clk); #1;
    send(32'h0000_0400, 32'h0050_0293, 32'h5, 5'd5, 1'b1, 1'b0,
         '0, '0, 1'b0, 1'b0, 1'b1);
    drain(40);

`ifdef RETIRE_TRACE_DMEM_EN
    // Store frame with dmem tail, hand-computed
    begin
      logic [7:0] bst [18];
      bst = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h23, 8'h22, 8'h11,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h00, 8'h00,
              8'h80, 8'h1F};
      for (int i = 0; i < 18; i++) sb.push_back({(i == 17), bst[i]});
      @(posedge clk); #1;
      send(32'h200, 32'h00112223, 32'h0, 5'd0, 1'b0, 1'b0,
           32'h80000004, 4'b1111, 1'b0, 1'b1, 1'b0);
      drain(40);
    end
`endif

    repeat (3) @(posedge clk);
    chk("final_idle", o_tvalid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
